// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with valid tracking, stall/flush control,
// a forwarding qualifier for the hazard unit and saturating debug counters.
module ex_mem_pipe_reg #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned REG_ADDR_WIDTH   = 5,
  parameter int unsigned RESULT_SRC_WIDTH = 2,
  parameter int unsigned CNT_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        StallM_i,
  input  logic                        FlushM_i,
  input  logic                        ValidE_i,
  input  logic [DATA_WIDTH-1:0]       ALUResultE_i,
  input  logic [DATA_WIDTH-1:0]       WriteDataE_i,
  input  logic [DATA_WIDTH-1:0]       PCPlus4E_i,
  input  logic [REG_ADDR_WIDTH-1:0]   RdE_i,
  input  logic                        RegWriteE_i,
  input  logic                        MemWriteE_i,
  input  logic [RESULT_SRC_WIDTH-1:0] ResultSrcE_i,
  input  logic [2:0]                  Funct3E_i,
  output logic                        ValidM_o,
  output logic [DATA_WIDTH-1:0]       ALUResultM_o,
  output logic [DATA_WIDTH-1:0]       WriteDataM_o,
  output logic [DATA_WIDTH-1:0]       PCPlus4M_o,
  output logic [REG_ADDR_WIDTH-1:0]   RdM_o,
  output logic                        RegWriteM_o,
  output logic                        MemWriteM_o,
  output logic [RESULT_SRC_WIDTH-1:0] ResultSrcM_o,
  output logic [2:0]                  Funct3M_o,
  output logic                        FwdValidM_o,
  output logic [CNT_WIDTH-1:0]        StallCount_o,
  output logic [CNT_WIDTH-1:0]        FlushCount_o
);

  logic                        valid_d, valid_q;
  logic [DATA_WIDTH-1:0]       alu_result_d, alu_result_q;
  logic [DATA_WIDTH-1:0]       write_data_d, write_data_q;
  logic [DATA_WIDTH-1:0]       pc_plus4_d, pc_plus4_q;
  logic [REG_ADDR_WIDTH-1:0]   rd_d, rd_q;
  logic                        reg_write_d, reg_write_q;
  logic                        mem_write_d, mem_write_q;
  logic [RESULT_SRC_WIDTH-1:0] result_src_d, result_src_q;
  logic [2:0]                  funct3_d, funct3_q;
  logic [CNT_WIDTH-1:0]        stall_cnt_d, stall_cnt_q;
  logic [CNT_WIDTH-1:0]        flush_cnt_d, flush_cnt_q;

  // Next-state for the stage contents: flush beats stall, stall beats load.
  always_comb begin
    valid_d      = valid_q;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    pc_plus4_d   = pc_plus4_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    result_src_d = result_src_q;
    funct3_d     = funct3_q;
    if (FlushM_i) begin
      valid_d      = 1'b0;
      alu_result_d = '0;
      write_data_d = '0;
      pc_plus4_d   = '0;
      rd_d         = '0;
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      result_src_d = '0;
      funct3_d     = '0;
    end else if (!StallM_i) begin
      valid_d      = ValidE_i;
      alu_result_d = ALUResultE_i;
      write_data_d = WriteDataE_i;
      pc_plus4_d   = PCPlus4E_i;
      rd_d         = RdE_i;
      // An invalid instruction must never produce a write.
      reg_write_d  = RegWriteE_i & ValidE_i;
      mem_write_d  = MemWriteE_i & ValidE_i;
      result_src_d = ResultSrcE_i;
      funct3_d     = Funct3E_i;
    end
  end

  // Saturating event counters; stall counts even when a flush overrides it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallM_i && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (FlushM_i && (flush_cnt_q != {CNT_WIDTH{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      funct3_q     <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      funct3_q     <= funct3_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // Outputs come straight from registered state only.
  always_comb begin
    ValidM_o     = valid_q;
    ALUResultM_o = alu_result_q;
    WriteDataM_o = write_data_q;
    PCPlus4M_o   = pc_plus4_q;
    RdM_o        = rd_q;
    RegWriteM_o  = reg_write_q;
    MemWriteM_o  = mem_write_q;
    ResultSrcM_o = result_src_q;
    Funct3M_o    = funct3_q;
    FwdValidM_o  = valid_q & reg_write_q & (rd_q != '0);
    StallCount_o = stall_cnt_q;
    FlushCount_o = flush_cnt_q;
  end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: directed vector table, a counter saturation
// sequence on a narrow-counter instance, then random traffic against a model.
module tb_ex_mem_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_e, rw_e, mw_e;
  logic [31:0] alu_e, wd_e, pc_e;
  logic [4:0]  rd_e;
  logic [1:0]  rs_e;
  logic [2:0]  f3_e;

  logic        valid_m, rw_m, mw_m, fwd_m;
  logic [31:0] alu_m, wd_m, pc_m;
  logic [4:0]  rd_m;
  logic [1:0]  rs_m;
  logic [2:0]  f3_m;
  logic [15:0] sc_m, fc_m;

  logic        s_valid_m, s_rw_m, s_mw_m, s_fwd_m;
  logic [31:0] s_alu_m, s_wd_m, s_pc_m;
  logic [4:0]  s_rd_m;
  logic [1:0]  s_rs_m;
  logic [2:0]  s_f3_m;
  logic [3:0]  s_sc_m, s_fc_m;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_reg u_dut (
    .clk(clk), .rst(rst), .StallM_i(stall), .FlushM_i(flush), .ValidE_i(valid_e),
    .ALUResultE_i(alu_e), .WriteDataE_i(wd_e), .PCPlus4E_i(pc_e), .RdE_i(rd_e),
    .RegWriteE_i(rw_e), .MemWriteE_i(mw_e), .ResultSrcE_i(rs_e), .Funct3E_i(f3_e),
    .ValidM_o(valid_m), .ALUResultM_o(alu_m), .WriteDataM_o(wd_m), .PCPlus4M_o(pc_m),
    .RdM_o(rd_m), .RegWriteM_o(rw_m), .MemWriteM_o(mw_m), .ResultSrcM_o(rs_m),
    .Funct3M_o(f3_m), .FwdValidM_o(fwd_m), .StallCount_o(sc_m), .FlushCount_o(fc_m)
  );

  ex_mem_pipe_reg #(.CNT_WIDTH(4)) u_dut_small (
    .clk(clk), .rst(rst), .StallM_i(stall), .FlushM_i(flush), .ValidE_i(valid_e),
    .ALUResultE_i(alu_e), .WriteDataE_i(wd_e), .PCPlus4E_i(pc_e), .RdE_i(rd_e),
    .RegWriteE_i(rw_e), .MemWriteE_i(mw_e), .ResultSrcE_i(rs_e), .Funct3E_i(f3_e),
    .ValidM_o(s_valid_m), .ALUResultM_o(s_alu_m), .WriteDataM_o(s_wd_m),
    .PCPlus4M_o(s_pc_m), .RdM_o(s_rd_m), .RegWriteM_o(s_rw_m), .MemWriteM_o(s_mw_m),
    .ResultSrcM_o(s_rs_m), .Funct3M_o(s_f3_m), .FwdValidM_o(s_fwd_m),
    .StallCount_o(s_sc_m), .FlushCount_o(s_fc_m)
  );

  // Reference model: the instruction sitting in M plus plain integer counts.
  typedef struct {
    bit          valid, rw, mw;
    bit [31:0]   alu, wd, pc;
    bit [4:0]    rd;
    bit [1:0]    rs;
    bit [2:0]    f3;
  } m_t;

  m_t mdl;
  int sc_big, fc_big, sc_small, fc_small;

  function automatic int sat_inc(int v, int maxv);
    return (v < maxv) ? v + 1 : maxv;
  endfunction

  task automatic model_edge();
    m_t nxt;
    nxt = mdl;
    if (rst) begin
      nxt = '{default: 0};
      sc_big = 0; fc_big = 0; sc_small = 0; fc_small = 0;
    end else begin
      if (flush) nxt = '{default: 0};
      else if (!stall) begin
        nxt.valid = valid_e; nxt.alu = alu_e; nxt.wd = wd_e; nxt.pc = pc_e;
        nxt.rd = rd_e; nxt.rs = rs_e; nxt.f3 = f3_e;
        nxt.rw = rw_e && valid_e;
        nxt.mw = mw_e && valid_e;
      end
      if (stall) begin
        sc_big = sat_inc(sc_big, 65535); sc_small = sat_inc(sc_small, 15);
      end
      if (flush) begin
        fc_big = sat_inc(fc_big, 65535); fc_small = sat_inc(fc_small, 15);
      end
    end
    mdl = nxt;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    bit fwd;
    fwd = mdl.valid && mdl.rw && (mdl.rd != 0);
    chk("m.valid", 64'(valid_m), 64'(mdl.valid));
    chk("m.alu", 64'(alu_m), 64'(mdl.alu));
    chk("m.wd", 64'(wd_m), 64'(mdl.wd));
    chk("m.pc", 64'(pc_m), 64'(mdl.pc));
    chk("m.rd", 64'(rd_m), 64'(mdl.rd));
    chk("m.rw", 64'(rw_m), 64'(mdl.rw));
    chk("m.mw", 64'(mw_m), 64'(mdl.mw));
    chk("m.rs", 64'(rs_m), 64'(mdl.rs));
    chk("m.f3", 64'(f3_m), 64'(mdl.f3));
    chk("m.fwd", 64'(fwd_m), 64'(fwd));
    chk("m.stallcnt", 64'(sc_m), 64'(sc_big));
    chk("m.flushcnt", 64'(fc_m), 64'(fc_big));
    chk("s.fwd", 64'(s_fwd_m), 64'(fwd));
    chk("s.stallcnt", 64'(s_sc_m), 64'(sc_small));
    chk("s.flushcnt", 64'(s_fc_m), 64'(fc_small));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    string     name;
    bit        rst, stall, flush, valid, rw, mw;
    bit [31:0] alu, wd;
    bit [4:0]  rd;
    bit        x_valid, x_rw, x_mw, x_fwd;
    bit [31:0] x_alu, x_wd;
    bit [4:0]  x_rd;
    int        x_sc, x_fc;
  } vec_t;

  vec_t tbl[14];

  initial begin
    //          name        rst st fl va rw mw alu           wd           rd  | va rw mw fw alu          wd           rd sc fc
    tbl[0]  = '{"reset0",   1, 1, 1, 1, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 31, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0};
    tbl[1]  = '{"reset1",   1, 1, 1, 1, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 31, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0};
    tbl[2]  = '{"load",     0, 0, 0, 1, 1, 0, 32'h00001234, 32'h00000011, 5,  1, 1, 0, 1, 32'h00001234, 32'h00000011, 5, 0, 0};
    tbl[3]  = '{"load_x0",  0, 0, 0, 1, 1, 0, 32'h00001234, 32'h00000022, 0,  1, 1, 0, 0, 32'h00001234, 32'h00000022, 0, 0, 0};
    tbl[4]  = '{"preload",  0, 0, 0, 1, 1, 0, 32'hAAAAAAAA, 32'h00000033, 7,  1, 1, 0, 1, 32'hAAAAAAAA, 32'h00000033, 7, 0, 0};
    tbl[5]  = '{"stall1",   0, 1, 0, 1, 1, 0, 32'h55555555, 32'h00000044, 9,  1, 1, 0, 1, 32'hAAAAAAAA, 32'h00000033, 7, 1, 0};
    tbl[6]  = '{"stall2",   0, 1, 0, 1, 1, 0, 32'h55555555, 32'h00000044, 9,  1, 1, 0, 1, 32'hAAAAAAAA, 32'h00000033, 7, 2, 0};
    tbl[7]  = '{"stall3",   0, 1, 0, 1, 1, 0, 32'h55555555, 32'h00000044, 9,  1, 1, 0, 1, 32'hAAAAAAAA, 32'h00000033, 7, 3, 0};
    tbl[8]  = '{"release",  0, 0, 0, 1, 1, 0, 32'h55555555, 32'h00000044, 9,  1, 1, 0, 1, 32'h55555555, 32'h00000044, 9, 3, 0};
    tbl[9]  = '{"store",    0, 0, 0, 1, 0, 1, 32'h00000100, 32'h0000DEAD, 0,  1, 0, 1, 0, 32'h00000100, 32'h0000DEAD, 0, 3, 0};
    tbl[10] = '{"stl_fl",   0, 1, 1, 1, 1, 1, 32'h00000777, 32'h00000888, 4,  0, 0, 0, 0, 32'h0,        32'h0,        0, 4, 1};
    tbl[11] = '{"invalid",  0, 0, 0, 0, 1, 1, 32'h00000042, 32'h00000043, 3,  0, 0, 0, 0, 32'h00000042, 32'h00000043, 3, 4, 1};
    tbl[12] = '{"rst_stl",  1, 1, 0, 1, 1, 1, 32'h00000099, 32'h00000098, 2,  0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0};
    tbl[13] = '{"resume",   0, 0, 0, 1, 1, 0, 32'h0000BEEF, 32'h00000055, 1,  1, 1, 0, 1, 32'h0000BEEF, 32'h00000055, 1, 0, 0};

    mdl = '{default: 0};
    sc_big = 0; fc_big = 0; sc_small = 0; fc_small = 0;
    rst = 1; stall = 0; flush = 0; valid_e = 0; rw_e = 0; mw_e = 0;
    alu_e = 0; wd_e = 0; pc_e = 0; rd_e = 0; rs_e = 0; f3_e = 0;

    // Directed vectors.
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; stall = tbl[i].stall; flush = tbl[i].flush;
      valid_e = tbl[i].valid; rw_e = tbl[i].rw; mw_e = tbl[i].mw;
      alu_e = tbl[i].alu; wd_e = tbl[i].wd; rd_e = tbl[i].rd;
      pc_e = 32'h1000 + 32'(4 * i); rs_e = 2'(i); f3_e = 3'(i);
      if (i < 2) begin
        pc_e = 32'hFFFFFFFC; rs_e = 2'b11; f3_e = 3'b111;
      end
      step();
      chk({tbl[i].name, ".valid"}, 64'(valid_m), 64'(tbl[i].x_valid));
      chk({tbl[i].name, ".rw"}, 64'(rw_m), 64'(tbl[i].x_rw));
      chk({tbl[i].name, ".mw"}, 64'(mw_m), 64'(tbl[i].x_mw));
      chk({tbl[i].name, ".fwd"}, 64'(fwd_m), 64'(tbl[i].x_fwd));
      chk({tbl[i].name, ".alu"}, 64'(alu_m), 64'(tbl[i].x_alu));
      chk({tbl[i].name, ".wd"}, 64'(wd_m), 64'(tbl[i].x_wd));
      chk({tbl[i].name, ".rd"}, 64'(rd_m), 64'(tbl[i].x_rd));
      chk({tbl[i].name, ".sc"}, 64'(sc_m), 64'(tbl[i].x_sc));
      chk({tbl[i].name, ".fc"}, 64'(fc_m), 64'(tbl[i].x_fc));
      chk_model();
    end

    // Saturation: 20 stall cycles, narrow counter must stick at 15.
    rst = 0; flush = 0; stall = 1;
    for (int k = 1; k <= 20; k++) begin
      alu_e = $urandom;
      step();
      chk("sat.small", 64'(s_sc_m), 64'((k < 15) ? k : 15));
      chk("sat.big", 64'(sc_m), 64'(k));
      chk("sat.hold", 64'(alu_m), 64'(32'h0000BEEF));
    end
    rst = 1; stall = 1;
    step();
    chk("sat.rst_small", 64'(s_sc_m), 64'(0));
    chk("sat.rst_big", 64'(sc_m), 64'(0));
    chk_model();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      valid_e = ($urandom_range(0, 4) != 0);
      rw_e = 1'($urandom); mw_e = 1'($urandom);
      alu_e = $urandom; wd_e = $urandom; pc_e = $urandom;
      rd_e = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      rs_e = 2'($urandom); f3_e = 3'($urandom);
      step();
      chk_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
- Parametrised EX->MEM pipeline register for the pipelined RISC-V core.
- Carries the ALU result, store data, destination register, PC+4 and MEM/WB control from Execute to Memory.
- Adds a valid bit, stall (hold), flush (bubble insertion), a forwarding-qualifier output for the hazard unit, and saturating stall/flush event counters for performance debug.

Parameters:
DATA_WIDTH, 32, width of ALU result, store data and PC+4 fields
REG_ADDR_WIDTH, 5, width of destination register index
RESULT_SRC_WIDTH, 2, width of ResultSrc control field
CNT_WIDTH, 16, width of each saturating event counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
StallM_i  input  1  hold current contents (stage M cannot accept)
FlushM_i  input  1  replace incoming instruction with bubble
ValidE_i  input  1  instruction in EX is valid
ALUResultE_i  input  DATA_WIDTH  ALU result from EX
WriteDataE_i  input  DATA_WIDTH  store data (forwarded RD2) from EX
PCPlus4E_i  input  DATA_WIDTH  PC+4 from EX
RdE_i  input  REG_ADDR_WIDTH  destination register index
RegWriteE_i  input  1  register write enable
MemWriteE_i  input  1  data memory write enable
ResultSrcE_i  input  RESULT_SRC_WIDTH  writeback mux select
Funct3E_i  input  3  load/store size and sign
ValidM_o  output  1  stage M holds a valid instruction
ALUResultM_o  output  DATA_WIDTH  registered ALU result
WriteDataM_o  output  DATA_WIDTH  registered store data
PCPlus4M_o  output  DATA_WIDTH  registered PC+4
RdM_o  output  REG_ADDR_WIDTH  registered destination index
RegWriteM_o  output  1  registered, valid-qualified write enable
MemWriteM_o  output  1  registered, valid-qualified memory write enable
ResultSrcM_o  output  RESULT_SRC_WIDTH  registered writeback select
Funct3M_o  output  3  registered funct3
FwdValidM_o  output  1  combinational: ValidM_o & RegWriteM_o & (RdM_o != 0)
StallCount_o  output  CNT_WIDTH  cycles with StallM_i asserted
FlushCount_o  output  CNT_WIDTH  cycles with FlushM_i asserted

Behaviour:
- Single clock, rising edge only. Reset synchronous, active-high.
- Per-edge priority: rst > FlushM_i > StallM_i > load.
- rst: every registered output and both counters go to 0. ValidM_o=0, so FwdValidM_o=0.
- Flush: all fields go to 0 (bubble). ValidM_o=0, RegWriteM_o=0, MemWriteM_o=0.
  - Flush overrides a simultaneous stall; a bubble is inserted, not the held value.
- Stall (no flush): every field holds its value; the EX inputs are ignored.
- Load (no stall, no flush): all fields capture the E inputs after one cycle of latency.
  - ValidM_o <= ValidE_i.
  - RegWriteM_o <= RegWriteE_i & ValidE_i; MemWriteM_o <= MemWriteE_i & ValidE_i. An invalid instruction can never write.
  - Data fields capture unconditionally.
- FwdValidM_o is purely combinational from registered state; no input-to-output path.
- Counters:
  - StallCount_o increments on each edge with StallM_i=1 and rst=0, including when flush is also high.
  - FlushCount_o increments on each edge with FlushM_i=1 and rst=0.
  - Both saturate at 2^CNT_WIDTH-1 and never wrap.
  - Cleared only by rst.
- Reset mid-stall or mid-flush: reset wins that edge. Normal operation resumes on the next edge with rst=0.
- No combinational path from any input to any output.

Test Plan:
1. Reset: drive rst=1 for 2 cycles with all inputs nonzero -> all outputs 0, FwdValidM_o=0, both counters 0.
2. Load: ValidE_i=1, ALUResultE_i=0x0000_1234, RdE_i=5, RegWriteE_i=1, no stall/flush -> next cycle ALUResultM_o=0x1234, RdM_o=5, ValidM_o=1, FwdValidM_o=1. Repeat with RdE_i=0 -> FwdValidM_o=0.
3. Stall: load 0xAAAA_AAAA, then StallM_i=1 for 3 cycles while ALUResultE_i=0x5555_5555 -> ALUResultM_o stays 0xAAAA_AAAA, StallCount_o=3. Release stall -> 0x5555_5555 appears one cycle later.
4. Flush with stall: StallM_i=1 and FlushM_i=1 in the same cycle, with a valid store in M -> next cycle ValidM_o=0, MemWriteM_o=0, all data fields 0, StallCount_o and FlushCount_o each +1.
5. Invalid qualify: ValidE_i=0, RegWriteE_i=1, MemWriteE_i=1 -> RegWriteM_o=0, MemWriteM_o=0, ValidM_o=0.
6. Saturation: CNT_WIDTH=4, hold StallM_i=1 for 20 cycles -> StallCount_o reaches 15 and stays at 15. Then rst=1 for 1 cycle -> StallCount_o=0.
